// File: rtl/read_from_uart_pkg.sv
// ---------------------------------------------------------------------------
// read_from_uart_pkg
//   Shared UART definitions used by both the receiver and the transmitter:
//   the bps_SET code table, the matching divider values, the receiver FSM
//   state encoding and a couple of small helper functions.
//   A bit period is (divider + 1) clocks of the 50 MHz system clock.
// ---------------------------------------------------------------------------
package read_from_uart_pkg;

    // Baud selection codes as presented on bps_SET
    localparam logic [15:0] BPS_CODE_9600   = 16'd0;
    localparam logic [15:0] BPS_CODE_19200  = 16'd1;
    localparam logic [15:0] BPS_CODE_38400  = 16'd2;
    localparam logic [15:0] BPS_CODE_57600  = 16'd3;
    localparam logic [15:0] BPS_CODE_115200 = 16'd4;

    // Divider values for a 50 MHz clock (bit period = value + 1 clocks)
    localparam logic [15:0] DR_9600   = 16'd5207;
    localparam logic [15:0] DR_19200  = 16'd2603;
    localparam logic [15:0] DR_38400  = 16'd1301;
    localparam logic [15:0] DR_57600  = 16'd867;
    localparam logic [15:0] DR_115200 = 16'd433;

    // Receiver FSM state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    // Map a baud code to its divider; unknown codes fall back to dflt
    function automatic logic [15:0] bps_code_to_dr(input logic [15:0] code,
                                                   input logic [15:0] dflt);
        logic [15:0] dr;
        case (code)
            BPS_CODE_9600:   dr = DR_9600;
            BPS_CODE_19200:  dr = DR_19200;
            BPS_CODE_38400:  dr = DR_38400;
            BPS_CODE_57600:  dr = DR_57600;
            BPS_CODE_115200: dr = DR_115200;
            default:         dr = dflt;
        endcase
        return dr;
    endfunction

    // Two-out-of-three vote, used to reject single-clock line spikes
    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/read_from_uart_bps_lut.sv
// ---------------------------------------------------------------------------
// read_from_uart_bps_lut
//   Registered baud-code to divider map. The divider output follows bps_set
//   one clock later and holds DR_DEFAULT while in reset. Shared with the
//   transmitter so both directions decode the code table identically.
// Ports
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous active-low reset
//   bps_set  in   16  baud code
//   bps_dr   out  16  registered divider value (bit period = bps_dr + 1)
// ---------------------------------------------------------------------------
module read_from_uart_bps_lut
    import read_from_uart_pkg::*;
#(
    parameter logic [15:0] DR_DEFAULT = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bps_set,
    output logic [15:0] bps_dr
);

    logic [15:0] bps_dr_d;
    logic [15:0] bps_dr_q;

    always_comb begin
        bps_dr_d = bps_code_to_dr(bps_set, DR_DEFAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bps_dr_q <= DR_DEFAULT;
        end else begin
            bps_dr_q <= bps_dr_d;
        end
    end

    assign bps_dr = bps_dr_q;

endmodule

// File: rtl/read_from_uart.sv
// ---------------------------------------------------------------------------
// read_from_uart
//   8N1 UART receiver, LSB first, idle-high line. The serial input is
//   synchronised, majority filtered over three clocks and decoded by a
//   four-state FSM that samples each bit at its centre. Good bytes are
//   presented on Rx_Data with a one-cycle Rx_Done; a low stop bit discards
//   the byte and raises a one-cycle Frame_Err instead.
// Ports
//   Clk        in   1   system clock (50 MHz)
//   Rst        in   1   asynchronous active-low reset
//   uart_rxd   in   1   serial input, asynchronous to Clk
//   bps_SET    in   16  baud code (0..4 = 9600..115200, other = 115200)
//   Rx_Data    out  8   last correctly received byte
//   Rx_Done    out  1   one-cycle strobe, Rx_Data just updated
//   Frame_Err  out  1   one-cycle strobe, stop bit was low
//   uart_state out  1   high while a frame is being received
// ---------------------------------------------------------------------------
module read_from_uart
    import read_from_uart_pkg::*;
#(
    parameter logic [15:0] DR_DEFAULT = 16'd433,
    // Must be at least 2
    parameter int          SYNC_STG   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        uart_rxd,
    input  logic [15:0] bps_SET,
    output logic [7:0]  Rx_Data,
    output logic        Rx_Done,
    output logic        Frame_Err,
    output logic        uart_state
);

    // Divider selected by the current baud code, one clock behind bps_SET
    logic [15:0] bps_dr;

    read_from_uart_bps_lut #(
        .DR_DEFAULT (DR_DEFAULT)
    ) u_bps_lut (
        .clk     (Clk),
        .rst_n   (Rst),
        .bps_set (bps_SET),
        .bps_dr  (bps_dr)
    );

    // -----------------------------------------------------------------------
    // Input synchroniser and 3-bit history. rx_h_q[0] is the newest sample.
    // Everything resets to the idle (high) level so that leaving reset never
    // looks like a start edge.
    // -----------------------------------------------------------------------
    logic [SYNC_STG-1:0] sync_d;
    logic [SYNC_STG-1:0] sync_q;
    logic [2:0]          rx_h_d;
    logic [2:0]          rx_h_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], uart_rxd};
        rx_h_d = {rx_h_q[1:0], sync_q[SYNC_STG-1]};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_q <= '1;
            rx_h_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
            rx_h_q <= rx_h_d;
        end
    end

    logic sample;
    logic fall_edge;

    assign sample    = majority3(rx_h_q);
    assign fall_edge = rx_h_q[1] & ~rx_h_q[0];

    // -----------------------------------------------------------------------
    // Receiver FSM and datapath
    // -----------------------------------------------------------------------
    uart_rx_state_e state_d;
    uart_rx_state_e state_q;
    logic [15:0]    div_cnt_d;
    logic [15:0]    div_cnt_q;
    logic [2:0]     bit_cnt_d;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shreg_d;
    logic [7:0]     shreg_q;
    logic [15:0]    cur_dr_d;
    logic [15:0]    cur_dr_q;
    logic [7:0]     rx_data_d;
    logic [7:0]     rx_data_q;
    logic           rx_done_d;
    logic           rx_done_q;
    logic           frame_err_d;
    logic           frame_err_q;
    logic           uart_state_d;
    logic           uart_state_q;

    // Half-period point of the start bit; truncation puts it on or just
    // before the true centre.
    logic [15:0] mid;
    assign mid = cur_dr_q >> 1;

    // Divider counter runs freely and is cleared on every state change and
    // at every sample point, so each DATA/STOP sample lands one full bit
    // period after the previous one.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        cur_dr_d    = cur_dr_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                // The baud divider is frozen here for the whole frame
                if (fall_edge) begin
                    state_d  = START;
                    cur_dr_d = bps_dr;
                end
            end

            START: begin
                if (div_cnt_q == mid) begin
                    div_cnt_d = '0;
                    if (sample) begin
                        // Line went back high before mid start bit: glitch
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end

            DATA: begin
                if (div_cnt_q == cur_dr_q) begin
                    div_cnt_d          = '0;
                    shreg_d[bit_cnt_q] = sample;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end

            STOP: begin
                // Return to IDLE at the stop-bit centre so that the next
                // start edge can be caught with no idle gap.
                if (div_cnt_q == cur_dr_q) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                    if (sample) begin
                        rx_data_d = shreg_q;
                        rx_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                div_cnt_d = '0;
            end
        endcase

        uart_state_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            cur_dr_q     <= DR_DEFAULT;
            rx_data_q    <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            uart_state_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            cur_dr_q     <= cur_dr_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            uart_state_q <= uart_state_d;
        end
    end

    assign Rx_Data    = rx_data_q;
    assign Rx_Done    = rx_done_q;
    assign Frame_Err  = frame_err_q;
    assign uart_state = uart_state_q;

endmodule
